// File: rtl/imem_arbiter_if.sv
// Bus bundle between the fetch unit, program loader, instruction RAM and imem_arbiter.
// The arbiter takes the slave view; the requester/RAM side takes the master view.
interface imem_arbiter_if #(
   parameter int unsigned XLEN   = 32,
   parameter int unsigned SIZE_W = 2
);
   logic              flush_flag;

   logic              f_req_valid;
   logic [XLEN-1:0]   f_req_addr;
   logic              f_req_ready;
   logic              f_rsp_valid;
   logic [XLEN-1:0]   f_rsp_addr;
   logic [XLEN-1:0]   f_rsp_data;

   logic              ld_valid;
   logic [XLEN-1:0]   ld_addr;
   logic [XLEN-1:0]   ld_data;
   logic [SIZE_W-1:0] ld_size;
   logic              ld_ready;

   logic              ram_en;
   logic              ram_read_flag;
   logic [XLEN-1:0]   ram_read_addr;
   logic              ram_write_flag;
   logic [XLEN-1:0]   ram_write_addr;
   logic [XLEN-1:0]   ram_write_data;
   logic [SIZE_W-1:0] ram_write_size;
   logic [XLEN-1:0]   ram_read_data;

   modport slave (
      input  flush_flag, f_req_valid, f_req_addr, ld_valid, ld_addr, ld_data, ld_size,
             ram_read_data,
      output f_req_ready, f_rsp_valid, f_rsp_addr, f_rsp_data, ld_ready,
             ram_en, ram_read_flag, ram_read_addr, ram_write_flag, ram_write_addr,
             ram_write_data, ram_write_size
   );

   modport master (
      output flush_flag, f_req_valid, f_req_addr, ld_valid, ld_addr, ld_data, ld_size,
             ram_read_data,
      input  f_req_ready, f_rsp_valid, f_rsp_addr, f_rsp_data, ld_ready,
             ram_en, ram_read_flag, ram_read_addr, ram_write_flag, ram_write_addr,
             ram_write_data, ram_write_size
   );
endinterface

// File: rtl/imem_arbiter.sv
// Shares one synchronous instruction RAM between the fetch path and the program loader,
// with a bounded loader burst so fetch cannot starve and flush squashing of fetch responses.
module imem_arbiter #(
   parameter int unsigned       XLEN          = 32,
   parameter int unsigned       SIZE_W        = 2,
   parameter logic [SIZE_W-1:0] NO_STORE_CODE = '0,
   parameter int unsigned       LD_BURST_MAX  = 4
) (
   input logic           clk,
   input logic           rst,
   imem_arbiter_if.slave bus
);

   localparam int unsigned      CNT_W     = 4;
   localparam logic [CNT_W-1:0] BURST_LIM = CNT_W'(LD_BURST_MAX);

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_FETCH = 2'd1,
      ARB_LOAD  = 2'd2
   } arb_state_e;

   arb_state_e       state;
   logic [CNT_W-1:0] burst_cnt;
   logic [XLEN-1:0]  rsp_addr_q;
   logic             f_grant;
   logic             ld_grant;

   // Grant decision: loader first unless fetch is waiting and the burst budget is spent.
   always_comb begin
      ld_grant = 1'b0;
      f_grant  = 1'b0;
      if (rst) begin
         ld_grant = bus.ld_valid && (!bus.f_req_valid || (burst_cnt < BURST_LIM));
         f_grant  = bus.f_req_valid && !ld_grant;
      end
   end

   // RAM command and requester-facing outputs.
   always_comb begin
      bus.f_req_ready    = f_grant;
      bus.ld_ready       = ld_grant;
      bus.ram_en         = f_grant || ld_grant;
      bus.ram_read_flag  = f_grant;
      bus.ram_read_addr  = '0;
      bus.ram_write_flag = ld_grant;
      bus.ram_write_addr = '0;
      bus.ram_write_data = '0;
      bus.ram_write_size = NO_STORE_CODE;
      if (f_grant) begin
         bus.ram_read_addr = bus.f_req_addr;
      end
      if (ld_grant) begin
         bus.ram_write_addr = bus.ld_addr;
         bus.ram_write_data = bus.ld_data;
         bus.ram_write_size = bus.ld_size;
      end
   end

   // A fetch granted last cycle has its word on ram_read_data now; flush or reset hides it.
   always_comb begin
      bus.f_rsp_valid = rst && !bus.flush_flag && (state == ARB_FETCH);
      bus.f_rsp_addr  = rsp_addr_q;
      bus.f_rsp_data  = bus.ram_read_data;
   end

   // Last-grant state, loader burst counter and response address.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= ARB_IDLE;
         burst_cnt  <= '0;
         rsp_addr_q <= '0;
      end else begin
         if (ld_grant) begin
            state <= ARB_LOAD;
         end else if (f_grant) begin
            state <= ARB_FETCH;
         end else begin
            state <= ARB_IDLE;
         end

         if (f_grant || !bus.f_req_valid) begin
            burst_cnt <= '0;
         end else if (ld_grant && (burst_cnt < BURST_LIM)) begin
            burst_cnt <= burst_cnt + CNT_W'(1);
         end

         if (f_grant) begin
            rsp_addr_q <= bus.f_req_addr;
         end
      end
   end

endmodule

// File: tb/tb_imem_arbiter.sv
// Self-checking bench for imem_arbiter: directed scenarios plus randomized traffic
// compared against a cycle-level reference model and a behavioural RAM.
module tb_imem_arbiter;
   localparam int unsigned XLEN     = 32;
   localparam int unsigned SIZE_W   = 2;
   localparam int unsigned BURST    = 4;
   localparam logic [1:0]  NO_STORE = 2'b00;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   imem_arbiter_if #(.XLEN(XLEN), .SIZE_W(SIZE_W)) bus ();

   imem_arbiter #(
      .XLEN(XLEN), .SIZE_W(SIZE_W), .NO_STORE_CODE(NO_STORE), .LD_BURST_MAX(BURST)
   ) dut (
      .clk(clk), .rst(rst), .bus(bus.slave)
   );

   // Behavioural synchronous RAM, 64 words.
   logic [31:0] ram [64];
   always @(posedge clk) begin
      if (bus.ram_en && bus.ram_write_flag) ram[bus.ram_write_addr[7:2]] <= bus.ram_write_data;
      if (bus.ram_en && bus.ram_read_flag) bus.ram_read_data <= ram[bus.ram_read_addr[7:2]];
   end

   int errors = 0;
   int checks = 0;

   // Reference model state
   int          m_burst = 0;
   bit          m_pend = 1'b0;
   logic [31:0] m_pend_addr = 32'h0;
   logic [31:0] shadow [64];
   bit          e_ld, e_f, e_rv;
   logic [31:0] e_ra, e_rd;

   task automatic predict();
      e_ld = rst && bus.ld_valid && (!bus.f_req_valid || m_burst < int'(BURST));
      e_f  = rst && bus.f_req_valid && !e_ld;
      e_rv = rst && m_pend && !bus.flush_flag;
      e_ra = m_pend_addr;
      e_rd = shadow[m_pend_addr[7:2]];
   endtask

   task automatic step();
      predict();
      @(negedge clk);
   endtask

   task automatic tick();
      @(posedge clk);
      if (!rst) begin
         m_burst = 0; m_pend = 1'b0; m_pend_addr = 32'h0;
      end else begin
         if (e_ld) shadow[bus.ld_addr[7:2]] = bus.ld_data;
         if (!bus.f_req_valid || e_f) m_burst = 0;
         else if (e_ld) m_burst++;
         m_pend = e_f;
         if (e_f) m_pend_addr = bus.f_req_addr;
      end
      #1;
   endtask

   task automatic set_idle();
      bus.flush_flag = 1'b0; bus.f_req_valid = 1'b0; bus.ld_valid = 1'b0;
      bus.f_req_addr = 32'h0; bus.ld_addr = 32'h0; bus.ld_data = 32'h0; bus.ld_size = NO_STORE;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      bus.flush_flag = 1'b0; bus.f_req_valid = 1'b1; bus.ld_valid = 1'b1;
      bus.f_req_addr = 32'h4; bus.ld_addr = 32'h8; bus.ld_data = $urandom; bus.ld_size = 2'b10;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (bus.f_req_ready !== 1'b0 || bus.ld_ready !== 1'b0) begin
            errors++; $display("FAIL reset_grants c%0d: f_req_ready=%b ld_ready=%b want 0/0", i, bus.f_req_ready, bus.ld_ready);
         end
         checks++;
         if (bus.ram_en !== 1'b0 || bus.ram_read_flag !== 1'b0 || bus.ram_write_flag !== 1'b0 || bus.ram_write_size !== NO_STORE) begin
            errors++; $display("FAIL reset_ram c%0d: en=%b rd=%b wr=%b size=%b want 0/0/0/%b", i, bus.ram_en, bus.ram_read_flag, bus.ram_write_flag, bus.ram_write_size, NO_STORE);
         end
         checks++;
         if (bus.f_rsp_valid !== 1'b0) begin
            errors++; $display("FAIL reset_rsp_valid c%0d: got %b want 0", i, bus.f_rsp_valid);
         end
         tick();
      end
      rst = 1'b1;
      step();
      checks++;
      if (bus.ld_ready !== 1'b1 || bus.f_req_ready !== 1'b0) begin
         errors++; $display("FAIL reset_release_grant: ld_ready=%b f_req_ready=%b want 1/0", bus.ld_ready, bus.f_req_ready);
      end
      checks++;
      if (bus.f_rsp_valid !== 1'b0 || bus.f_rsp_addr !== 32'h0) begin
         errors++; $display("FAIL reset_release_rsp: valid=%b addr=%h want 0/00000000", bus.f_rsp_valid, bus.f_rsp_addr);
      end
      tick();
      set_idle(); step(); tick();
   endtask

   task automatic test_preload();
      for (int i = 0; i < 64; i++) begin
         set_idle();
         bus.ld_valid = 1'b1; bus.ld_addr = 32'(i * 4); bus.ld_data = $urandom; bus.ld_size = 2'b10;
         step();
         checks++;
         if (bus.ld_ready !== 1'b1 || bus.ram_write_flag !== 1'b1 || bus.ram_write_addr !== bus.ld_addr ||
             bus.ram_write_data !== bus.ld_data || bus.ram_write_size !== 2'b10 || bus.ram_read_flag !== 1'b0) begin
            errors++; $display("FAIL preload_write %0d: ready=%b wr=%b addr=%h data=%h size=%b want 1/1/%h/%h/10",
                               i, bus.ld_ready, bus.ram_write_flag, bus.ram_write_addr, bus.ram_write_data, bus.ram_write_size, bus.ld_addr, bus.ld_data);
         end
         tick();
      end
      set_idle(); step(); tick();
   endtask

   task automatic test_fetch_stream();
      for (int i = 0; i < 6; i++) begin
         set_idle();
         if (i < 3) begin bus.f_req_valid = 1'b1; bus.f_req_addr = 32'(i * 4); end
         step();
         checks++;
         if (bus.f_req_ready !== (i < 3) || bus.ram_read_flag !== (i < 3)) begin
            errors++; $display("FAIL stream_grant c%0d: ready=%b rd=%b want %b", i, bus.f_req_ready, bus.ram_read_flag, (i < 3));
         end
         checks++;
         if (bus.f_rsp_valid !== (i >= 1 && i <= 3)) begin
            errors++; $display("FAIL stream_valid c%0d: got %b want %b", i, bus.f_rsp_valid, (i >= 1 && i <= 3));
         end
         if (i >= 1 && i <= 3) begin
            checks++;
            if (bus.f_rsp_addr !== 32'((i - 1) * 4) || bus.f_rsp_data !== shadow[i - 1]) begin
               errors++; $display("FAIL stream_data c%0d: addr=%h data=%h want %h/%h", i, bus.f_rsp_addr, bus.f_rsp_data, 32'((i - 1) * 4), shadow[i - 1]);
            end
         end
         tick();
      end
   endtask

   task automatic test_starvation();
      for (int i = 0; i < 15; i++) begin
         bus.flush_flag = 1'b0;
         bus.f_req_valid = 1'b1; bus.f_req_addr = {24'h0, 6'($urandom), 2'b00};
         bus.ld_valid = 1'b1; bus.ld_addr = {24'h0, 6'($urandom), 2'b00};
         bus.ld_data = $urandom; bus.ld_size = 2'b10;
         step();
         checks++;
         if (bus.f_req_ready !== (i % 5 == 4) || bus.ld_ready !== (i % 5 != 4)) begin
            errors++; $display("FAIL starve_seq c%0d: f_req_ready=%b ld_ready=%b want %b/%b", i, bus.f_req_ready, bus.ld_ready, (i % 5 == 4), (i % 5 != 4));
         end
         checks++;
         if (bus.f_rsp_valid !== e_rv || (e_rv && bus.f_rsp_data !== e_rd)) begin
            errors++; $display("FAIL starve_rsp c%0d: valid=%b data=%h want %b/%h", i, bus.f_rsp_valid, bus.f_rsp_data, e_rv, e_rd);
         end
         tick();
      end
      set_idle(); step(); tick();
   endtask

   task automatic test_flush();
      set_idle(); bus.f_req_valid = 1'b1; bus.f_req_addr = 32'h10;
      step(); tick();
      bus.flush_flag = 1'b1; bus.f_req_addr = 32'h80;
      step();
      checks++;
      if (bus.f_rsp_valid !== 1'b0 || bus.f_req_ready !== 1'b1) begin
         errors++; $display("FAIL flush_squash: valid=%b ready=%b want 0/1", bus.f_rsp_valid, bus.f_req_ready);
      end
      tick();
      set_idle();
      step();
      checks++;
      if (bus.f_rsp_valid !== 1'b1 || bus.f_rsp_addr !== 32'h80 || bus.f_rsp_data !== shadow[32]) begin
         errors++; $display("FAIL flush_redirect: valid=%b addr=%h data=%h want 1/00000080/%h", bus.f_rsp_valid, bus.f_rsp_addr, bus.f_rsp_data, shadow[32]);
      end
      tick();
      step();
      checks++;
      if (bus.f_rsp_valid !== 1'b0) begin
         errors++; $display("FAIL flush_no_stale: valid=%b want 0", bus.f_rsp_valid);
      end
      tick();
   endtask

   task automatic test_load_then_fetch();
      set_idle(); bus.ld_valid = 1'b1; bus.ld_addr = 32'h20; bus.ld_data = 32'hDEADBEEF; bus.ld_size = 2'b10;
      step();
      checks++;
      if (bus.ld_ready !== 1'b1) begin
         errors++; $display("FAIL raw_load_grant: ld_ready=%b want 1", bus.ld_ready);
      end
      tick();
      set_idle(); bus.f_req_valid = 1'b1; bus.f_req_addr = 32'h20;
      step();
      checks++;
      if (bus.f_req_ready !== 1'b1 || bus.f_rsp_valid !== 1'b0) begin
         errors++; $display("FAIL raw_fetch_grant: ready=%b rsp_valid=%b want 1/0", bus.f_req_ready, bus.f_rsp_valid);
      end
      tick();
      set_idle();
      step();
      checks++;
      if (bus.f_rsp_valid !== 1'b1 || bus.f_rsp_addr !== 32'h20 || bus.f_rsp_data !== 32'hDEADBEEF) begin
         errors++; $display("FAIL raw_data: valid=%b addr=%h data=%h want 1/00000020/deadbeef", bus.f_rsp_valid, bus.f_rsp_addr, bus.f_rsp_data);
      end
      tick();
   endtask

   task automatic test_mid_reset();
      set_idle(); bus.f_req_valid = 1'b1; bus.f_req_addr = 32'h40;
      step(); tick();
      rst = 1'b0;
      step();
      checks++;
      if (bus.f_rsp_valid !== 1'b0 || bus.f_req_ready !== 1'b0) begin
         errors++; $display("FAIL midrst_during: valid=%b ready=%b want 0/0", bus.f_rsp_valid, bus.f_req_ready);
      end
      tick();
      rst = 1'b1; set_idle();
      for (int i = 0; i < 2; i++) begin
         step();
         checks++;
         if (bus.f_rsp_valid !== 1'b0 || bus.f_rsp_addr !== 32'h0) begin
            errors++; $display("FAIL midrst_after c%0d: valid=%b addr=%h want 0/00000000", i, bus.f_rsp_valid, bus.f_rsp_addr);
         end
         tick();
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         rst = ($urandom_range(0, 99) >= 3);
         bus.flush_flag  = ($urandom_range(0, 9) == 0);
         bus.f_req_valid = ($urandom_range(0, 9) < 7);
         bus.ld_valid    = ($urandom_range(0, 9) < 5);
         bus.f_req_addr  = {24'h0, 6'($urandom), 2'b00};
         bus.ld_addr     = {24'h0, 6'($urandom), 2'b00};
         bus.ld_data     = $urandom;
         bus.ld_size     = 2'($urandom_range(1, 3));
         step();
         checks++;
         if (bus.ld_ready !== e_ld || bus.f_req_ready !== e_f || bus.ram_en !== (e_ld || e_f)) begin
            errors++; $display("FAIL rnd_grant c%0d: ld=%b f=%b en=%b want %b/%b/%b", i, bus.ld_ready, bus.f_req_ready, bus.ram_en, e_ld, e_f, e_ld || e_f);
         end
         checks++;
         if (bus.ram_read_flag !== e_f || bus.ram_write_flag !== e_ld ||
             (e_f && bus.ram_read_addr !== bus.f_req_addr) ||
             (e_ld && (bus.ram_write_addr !== bus.ld_addr || bus.ram_write_data !== bus.ld_data || bus.ram_write_size !== bus.ld_size)) ||
             (!e_ld && bus.ram_write_size !== NO_STORE)) begin
            errors++; $display("FAIL rnd_ram c%0d: rd=%b wr=%b raddr=%h waddr=%h wdata=%h size=%b", i, bus.ram_read_flag, bus.ram_write_flag,
                               bus.ram_read_addr, bus.ram_write_addr, bus.ram_write_data, bus.ram_write_size);
         end
         checks++;
         if (bus.f_rsp_valid !== e_rv || (e_rv && (bus.f_rsp_addr !== e_ra || bus.f_rsp_data !== e_rd))) begin
            errors++; $display("FAIL rnd_rsp c%0d: valid=%b addr=%h data=%h want %b/%h/%h", i, bus.f_rsp_valid, bus.f_rsp_addr, bus.f_rsp_data, e_rv, e_ra, e_rd);
         end
         tick();
      end
      rst = 1'b1; set_idle(); step(); tick();
   endtask

   initial begin
      rst = 1'b0;
      set_idle();
      test_reset();
      test_preload();
      test_fetch_stream();
      test_starvation();
      test_flush();
      test_load_then_fetch();
      test_mid_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
